// File: rtl/procyon_types.sv
// Shared type and sizing definitions for the procyon load/store unit.
package procyon_types;

  localparam int unsigned SQ_DEPTH        = 8;
  localparam int unsigned SQ_TAG_WIDTH    = 6;
  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned MHQ_TAG_WIDTH   = 2;
  localparam int unsigned LSU_FUNC_WIDTH  = 4;

  typedef logic [DATA_WIDTH-1:0]    procyon_data_t;
  typedef logic [ADDR_WIDTH-1:0]    procyon_addr_t;
  typedef logic [SQ_TAG_WIDTH-1:0]  procyon_tag_t;
  typedef logic [MHQ_TAG_WIDTH-1:0] procyon_mhq_tag_t;

  typedef enum logic [LSU_FUNC_WIDTH-1:0] {
    LSU_FUNC_LB,
    LSU_FUNC_LH,
    LSU_FUNC_LW,
    LSU_FUNC_LBU,
    LSU_FUNC_LHU,
    LSU_FUNC_SB,
    LSU_FUNC_SH,
    LSU_FUNC_SW
  } procyon_lsu_func_t;

  typedef enum logic [2:0] {
    SQ_INVALID,
    SQ_VALID,
    SQ_RETIRED,
    SQ_LAUNCHED,
    SQ_MHQ_WAIT
  } sq_state_t;

endpackage

// File: rtl/lsu_sq_retire_fifo.sv
// In-order queue of retired store-slot indices; the head is the only store allowed to launch.
module lsu_sq_retire_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IDX_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_push,
  input  logic [IDX_WIDTH-1:0] i_push_idx,
  input  logic                 i_pop,
  output logic [IDX_WIDTH-1:0] o_head,
  output logic                 o_empty
);

  logic [IDX_WIDTH-1:0] entries [DEPTH];
  logic [IDX_WIDTH-1:0] rd_ptr;
  logic [IDX_WIDTH-1:0] wr_ptr;
  logic [IDX_WIDTH:0]   count;
  logic                 pop_do;

  assign o_empty = (count == '0);
  assign o_head  = entries[rd_ptr];
  assign pop_do  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) begin
        entries[wr_ptr] <= i_push_idx;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop_do) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({i_push, pop_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lsu_sq.sv
// Store queue: holds stores until ROB retirement, then commits them to LSU_EX one at a time in retire order.
module lsu_sq #(
  parameter int unsigned SQ_DEPTH     = procyon_types::SQ_DEPTH,
  parameter int unsigned SQ_IDX_WIDTH = $clog2(SQ_DEPTH)
) (
  input  logic                                        clk,
  input  logic                                        n_rst,
  input  logic                                        i_flush,
  output logic                                        o_full,
  input  logic                                        i_alloc_en,
  input  logic [procyon_types::SQ_TAG_WIDTH-1:0]      i_alloc_tag,
  input  logic [procyon_types::ADDR_WIDTH-1:0]        i_alloc_addr,
  input  logic [procyon_types::DATA_WIDTH-1:0]        i_alloc_data,
  input  logic [procyon_types::LSU_FUNC_WIDTH-1:0]    i_alloc_lsu_func,
  input  logic                                        i_rob_retire_en,
  input  logic [procyon_types::SQ_TAG_WIDTH-1:0]      i_rob_retire_tag,
  input  logic                                        i_launch_stall,
  output logic                                        o_launch_en,
  output logic [procyon_types::ADDR_WIDTH-1:0]        o_launch_addr,
  output logic [procyon_types::DATA_WIDTH-1:0]        o_launch_data,
  output logic [procyon_types::LSU_FUNC_WIDTH-1:0]    o_launch_lsu_func,
  output logic [procyon_types::SQ_TAG_WIDTH-1:0]      o_launch_tag,
  input  logic                                        i_update_sq_en,
  input  logic                                        i_update_sq_retry,
  input  logic [procyon_types::MHQ_TAG_WIDTH-1:0]     i_update_sq_mhq_tag,
  input  logic                                        i_mhq_fill,
  input  logic [procyon_types::MHQ_TAG_WIDTH-1:0]     i_mhq_fill_tag,
  output logic                                        o_sq_retire_en,
  output logic [procyon_types::ADDR_WIDTH-1:0]        o_sq_retire_addr,
  output logic [procyon_types::LSU_FUNC_WIDTH-1:0]    o_sq_retire_lsu_func
);

  import procyon_types::*;

  sq_state_t                 slot_state   [SQ_DEPTH];
  procyon_addr_t             slot_addr    [SQ_DEPTH];
  procyon_data_t             slot_data    [SQ_DEPTH];
  logic [LSU_FUNC_WIDTH-1:0] slot_func    [SQ_DEPTH];
  procyon_tag_t              slot_tag     [SQ_DEPTH];
  logic                      slot_retry   [SQ_DEPTH];
  procyon_mhq_tag_t          slot_mhq_tag [SQ_DEPTH];

  logic [SQ_DEPTH-1:0]     retire_match;
  logic [SQ_IDX_WIDTH-1:0] retire_idx;
  logic                    retire_any;
  logic [SQ_IDX_WIDTH-1:0] alloc_idx;
  logic                    alloc_found;
  logic                    alloc_do;
  logic                    any_busy;
  logic [SQ_IDX_WIDTH-1:0] head_idx;
  logic                    fifo_empty;
  sq_state_t               head_state;
  logic                    launch_ok;
  logic                    head_launched;
  logic                    launch_hit;
  logic                    fill_at_update;

  always_comb begin
    alloc_idx    = '0;
    alloc_found  = 1'b0;
    retire_match = '0;
    retire_idx   = '0;
    any_busy     = 1'b0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      if (slot_state[i] == SQ_INVALID && !alloc_found) begin
        alloc_idx   = SQ_IDX_WIDTH'(i);
        alloc_found = 1'b1;
      end
      if (i_rob_retire_en && slot_state[i] == SQ_VALID && slot_tag[i] == i_rob_retire_tag) begin
        retire_match[i] = 1'b1;
        retire_idx      = SQ_IDX_WIDTH'(i);
      end
      if (slot_state[i] == SQ_LAUNCHED || slot_state[i] == SQ_MHQ_WAIT) begin
        any_busy = 1'b1;
      end
    end
  end

  assign o_full     = !alloc_found;
  assign alloc_do   = i_alloc_en && alloc_found && !i_flush;
  assign retire_any = |retire_match;

  lsu_sq_retire_fifo #(
    .DEPTH     (SQ_DEPTH),
    .IDX_WIDTH (SQ_IDX_WIDTH)
  ) u_retire_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_push     (retire_any),
    .i_push_idx (retire_idx),
    .i_pop      (launch_hit),
    .o_head     (head_idx),
    .o_empty    (fifo_empty)
  );

  // Only the FIFO head ever launches, so a LAUNCHED slot is always the head.
  assign head_state     = slot_state[head_idx];
  assign launch_ok      = !fifo_empty && head_state == SQ_RETIRED && !any_busy;
  assign head_launched  = !fifo_empty && head_state == SQ_LAUNCHED;
  assign launch_hit     = head_launched && !i_update_sq_en;
  assign fill_at_update = i_mhq_fill && (i_update_sq_retry || i_update_sq_mhq_tag == i_mhq_fill_tag);

  assign o_launch_en       = launch_ok && !i_launch_stall;
  assign o_launch_addr     = slot_addr[head_idx];
  assign o_launch_data     = slot_data[head_idx];
  assign o_launch_lsu_func = slot_func[head_idx];
  assign o_launch_tag      = slot_tag[head_idx];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
        slot_state[i]   <= SQ_INVALID;
        slot_addr[i]    <= '0;
        slot_data[i]    <= '0;
        slot_func[i]    <= '0;
        slot_tag[i]     <= '0;
        slot_retry[i]   <= 1'b0;
        slot_mhq_tag[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
        case (slot_state[i])
          SQ_INVALID: begin
            if (alloc_do && alloc_idx == SQ_IDX_WIDTH'(i)) begin
              slot_state[i] <= SQ_VALID;
              slot_addr[i]  <= i_alloc_addr;
              slot_data[i]  <= i_alloc_data;
              slot_func[i]  <= i_alloc_lsu_func;
              slot_tag[i]   <= i_alloc_tag;
            end
          end
          SQ_VALID: begin
            // A retire in the flush cycle wins: the store is already committed.
            if (retire_match[i]) begin
              slot_state[i] <= SQ_RETIRED;
            end else if (i_flush) begin
              slot_state[i] <= SQ_INVALID;
            end
          end
          SQ_RETIRED: begin
            if (o_launch_en && head_idx == SQ_IDX_WIDTH'(i)) begin
              slot_state[i] <= SQ_LAUNCHED;
            end
          end
          SQ_LAUNCHED: begin
            if (!i_update_sq_en) begin
              slot_state[i] <= SQ_INVALID;
            end else begin
              slot_retry[i]   <= i_update_sq_retry;
              slot_mhq_tag[i] <= i_update_sq_mhq_tag;
              slot_state[i]   <= fill_at_update ? SQ_RETIRED : SQ_MHQ_WAIT;
            end
          end
          SQ_MHQ_WAIT: begin
            if (i_mhq_fill && (slot_retry[i] || slot_mhq_tag[i] == i_mhq_fill_tag)) begin
              slot_state[i] <= SQ_RETIRED;
            end
          end
          default: slot_state[i] <= SQ_INVALID;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_sq_retire_en       <= 1'b0;
      o_sq_retire_addr     <= '0;
      o_sq_retire_lsu_func <= '0;
    end else begin
      o_sq_retire_en <= launch_hit;
      if (launch_hit) begin
        o_sq_retire_addr     <= slot_addr[head_idx];
        o_sq_retire_lsu_func <= slot_func[head_idx];
      end
    end
  end

endmodule

// File: doc/lsu_sq.md
# lsu_sq

Store queue for the load/store unit. Holds issued store ops, including address, data and width, until the ROB retires them. It then commits retired stores to the D-cache through LSU_EX strictly in retire order, one at a time. Each completed store's address range is broadcast to `lsu_lq` for mis-speculation detection. The block sits beside `lsu_lq`: fed by LSU_ID and the ROB, feeding LSU_EX and the LQ.

## Interface
Parameters:
- `SQ_DEPTH`, default `SQ_DEPTH` from package (8). Number of store slots; power of two, ≥2.
- `SQ_IDX_WIDTH`, default `$clog2(SQ_DEPTH)`. Slot index width.

Ports:
- `clk` in 1: clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `i_flush` in 1: pipeline flush.
- `o_full` out 1: no free slot.
- `i_alloc_en`, `i_alloc_tag`, `i_alloc_addr`, `i_alloc_data`, `i_alloc_lsu_func` in 1/tag/addr/data/func: allocate a store from LSU_ID.
- `i_rob_retire_en`, `i_rob_retire_tag` in 1/tag: ROB retires the store with this tag.
- `i_launch_stall` in 1: LSU_EX cannot accept a store this cycle.
- `o_launch_en`, `o_launch_addr`, `o_launch_data`, `o_launch_lsu_func`, `o_launch_tag` out 1/addr/data/func/tag: store sent to LSU_EX.
- `i_update_sq_en` in 1: launched store missed; it must be relaunched.
- `i_update_sq_retry` in 1: the miss found the MHQ full; any fill re-arms.
- `i_update_sq_mhq_tag` in mhq_tag: MHQ entry the store waits on.
- `i_mhq_fill`, `i_mhq_fill_tag` in 1/mhq_tag: MHQ fill broadcast.
- `o_sq_retire_en`, `o_sq_retire_addr`, `o_sq_retire_lsu_func` out 1/addr/func: completed-store broadcast to LQ.

## Operation
- Slot state: INVALID → VALID (allocated) → RETIRED (ROB retired; index queued in retire FIFO) → LAUNCHED → INVALID (hit), or LAUNCHED → MHQ_WAIT (miss) → RETIRED (fill) → LAUNCHED again.
- Allocation:
  - Lowest-index INVALID slot.
  - Ignored when `o_full`.
  - `o_full` = no INVALID slot, combinational from state.
- ROB retire:
  - Tag compared against all VALID slots; the matching slot becomes RETIRED and its index is pushed into the retire FIFO.
  - No match: ignored.
  - Only one match is legal.
- Launch:
  - Only the FIFO head may launch, and only when head is RETIRED and no slot is LAUNCHED or MHQ_WAIT.
  - At most one store is outstanding.
  - `o_launch_en` = eligible && ~`i_launch_stall`; fields come from the head slot, combinationally.
- Result: sampled in the cycle after launch (L+1).
  - `i_update_sq_en`=1: slot → MHQ_WAIT, latch retry and mhq_tag.
  - `i_update_sq_en`=0: slot → INVALID, FIFO pop, broadcast registered.
- Fill:
  - A MHQ_WAIT slot with retry=1, or with a matching tag, returns to RETIRED.
  - FIFO head is unchanged, so the same store relaunches.
- Flush:
  - VALID slots → INVALID.
  - RETIRED/LAUNCHED/MHQ_WAIT slots and the FIFO are untouched; committed stores must drain.
- Widths:
  - `o_sq_retire_addr` is the store start address.
  - The LQ derives the range from the lsu_func (SB 1, SH 2, SW 4 bytes).

## Timing
- Reset values:
  - All slots INVALID; FIFO empty.
  - `o_full`=0, `o_launch_en`=0, `o_sq_retire_en`=0.
  - Address, func and data outputs are 0.
- Allocation: slot visible VALID at L+1; a ROB retire for it is legal from L+1.
- Launch at L; miss/hit decision at L+1; `o_sq_retire_en` pulses exactly one cycle at L+2.
- Earliest next launch for a hit: L+2, because the pop takes effect end of L+1.
- Earliest relaunch for a miss: the cycle after the fill.
- Simultaneous events:
  - **Fill in L+1 with a matching tag or retry, together with an update:** slot goes directly to RETIRED, not MHQ_WAIT.
  - **`i_flush` + `i_rob_retire_en` matching a VALID slot:** retire wins; slot → RETIRED.
  - **`i_flush` + `i_alloc_en`:** allocation dropped.
  - **Allocate + retire into a full SQ:** allocation still dropped that cycle; `o_full` is based on current state.
  - **`i_launch_stall` held:** head stays RETIRED, no state change.
- Reset mid-operation: all state cleared asynchronously, including in-flight and MHQ_WAIT stores.

## Structure
- Shared package `procyon_types`:
  - `SQ_DEPTH`, `SQ_TAG_WIDTH`.
  - `sq_state_t` enum (INVALID, VALID, RETIRED, LAUNCHED, MHQ_WAIT).
  - `procyon_data_t`, reused `procyon_lsu_func_t` and `procyon_mhq_tag_t`.
- Sub-module `lsu_sq_retire_fifo`:
  - Synchronous FIFO of `SQ_IDX_WIDTH` entries, depth `SQ_DEPTH`, push/pop/head/empty.
  - Never overflows, since at most `SQ_DEPTH` slots can be RETIRED.

## Test plan
- Alloc tag 3, addr 0x100, SW, data 0xDEADBEEF; ROB retire tag 3; no update at L+1. Required: `o_launch_en` with those fields, then `o_sq_retire_en` at L+2 with addr 0x100, SW; slot freed.
- Alloc tags 5, 6 to slots 0 and 1; retire 6 then 5. Required: launch order is tag 6 then tag 5, and tag 5 does not launch before tag 6 completes.
- Launch, then update at L+1 with mhq_tag 2, retry 0. Required: no relaunch on fill tag 1; relaunch the cycle after fill tag 2. With retry=1, fill tag 1 re-arms the store.
- Fill `SQ_DEPTH` stores, 4 of them retired. Required: `o_full`=1 and alloc ignored. Then flush: `o_full`=0, the 4 retired stores still launch and broadcast in order, and the others never launch.
- Launch with `i_launch_stall` held 3 cycles. Required: `o_launch_en`=0 throughout, then launch on release.
- Assert `n_rst` while a store is in MHQ_WAIT. Required: all outputs 0, and no launch after reset release.
